// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serialising memory controller.
// The ERR state only exists when MEM_ALIGN_CHK_EN is defined.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_DONE   = 3'd3;
`ifdef MEM_ALIGN_CHK_EN
    localparam state_t ST_ERR    = 3'd4;
`endif

    function automatic logic [3:0] n_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_ext.sv
// Sign/zero extension of an assembled little-endian load to 64 bits.
module mem_ext
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsgn_i,
    input  logic [63:0] raw_i,
    output logic [63:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (size_i)
            SZ_B:    ext_o = {{56{~unsgn_i & raw_i[7]}},  raw_i[7:0]};
            SZ_H:    ext_o = {{48{~unsgn_i & raw_i[15]}}, raw_i[15:0]};
            SZ_W:    ext_o = {{32{~unsgn_i & raw_i[31]}}, raw_i[31:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Splits a 1/2/4/8-byte CPU access into ascending single-byte RAM accesses.
// Define MEM_ALIGN_CHK_EN to reject misaligned requests with err.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MADDR_SZ = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                wr,
    input  logic [1:0]          size,
    input  logic                unsgn,
    input  logic [MADDR_SZ-1:0] addr,
    input  logic [63:0]         wdata,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [63:0]         rdata,
    output logic [MADDR_SZ-1:0] ram_raddr,
    output logic [MADDR_SZ-1:0] ram_waddr,
    output logic [7:0]          ram_din,
    input  logic [7:0]          ram_dout,
    output logic                ram_re,
    output logic                ram_we
);

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic                unsgn_q, unsgn_d;
    logic [MADDR_SZ-1:0] addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [2:0]          idx_q, idx_d;
    logic [63:0]         buf_q, buf_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [63:0]         ext;
    logic [2:0]          last_idx;

    assign last_idx = 3'(n_bytes(size_q) - 4'd1);

    mem_ext u_ext (
        .size_i  (size_q),
        .unsgn_i (unsgn_q),
        .raw_i   (buf_q),
        .ext_o   (ext)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        unsgn_d = unsgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    unsgn_d = unsgn;
                    addr_d  = addr;
                    wdata_d = wdata;
                    idx_d   = '0;
                    buf_d   = '0;
`ifdef MEM_ALIGN_CHK_EN
                    if ((addr[2:0] & 3'(n_bytes(size) - 4'd1)) != 3'd0)
                        state_d = ST_ERR;
                    else
                        state_d = ST_SETUP;
`else
                    state_d = ST_SETUP;
`endif
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (!wr_q)
                    buf_d[{idx_q, 3'b000} +: 8] = ram_dout;
                if (idx_q == last_idx) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                if (!wr_q)
                    rdata_d = ext;
                state_d = ST_IDLE;
            end
`ifdef MEM_ALIGN_CHK_EN
            ST_ERR: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes come straight from flops so the RAM never sees a decode glitch.
    always_comb begin
        re_d = (state_d == ST_STROBE) && !wr_q;
        we_d = (state_d == ST_STROBE) &&  wr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_B;
            unsgn_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            unsgn_q <= unsgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign ram_raddr = addr_q + MADDR_SZ'(idx_q);
    assign ram_waddr = addr_q + MADDR_SZ'(idx_q);
    assign ram_din   = wdata_q[{idx_q, 3'b000} +: 8];
    assign ram_re    = re_q;
    assign ram_we    = we_q;

    // The load result is shown live during DONE and registered as DONE is left.
    assign rdata = (state_q == ST_DONE && !wr_q) ? ext : rdata_q;

`ifdef MEM_ALIGN_CHK_EN
    assign done = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign err  = (state_q == ST_ERR);
`else
    assign done = (state_q == ST_DONE);
    assign err  = 1'b0;
`endif

endmodule
